// File: rtl/gpu_mem_pkg.sv
// Shared types for the GPU DRAM request path.
//   arb_state_t : arbiter FSM encoding (ARB -> CMD -> RSP [-> DRAIN] -> ARB)
//   mem_req_t   : one latched single-beat request (write flag, address, write data)
//   MEM_ADDR_W / MEM_DATA_W bound the request fields; arbiter widths must not exceed them.
package gpu_mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        CMD   = 2'd1,
        RSP   = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector
//   ptr        : highest-priority index this round (must be < N)
//   gnt_onehot : winner as a one-hot vector, zero when no request
//   gnt_idx    : winner index (0 when no request)
//   any        : at least one request present
// The request vector is duplicated so that a search starting at ptr and wrapping
// past N-1 becomes a plain lowest-set-bit search over 2N bits.
module rr_pick #(
    parameter  int N  = 3,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    logic [2*N-1:0] dbl_s;
    logic [2*N-1:0] masked_s;
    logic [2*N-1:0] first_s;

    // Mask off positions below ptr, isolate the lowest surviving bit, fold halves.
    always_comb begin
        dbl_s      = {req, req};
        masked_s   = dbl_s & ({(2*N){1'b1}} << ptr);
        first_s    = masked_s & (~masked_s + (2*N)'(1'b1));
        gnt_onehot = first_s[N-1:0] | first_s[2*N-1:N];
        any        = |req;
    end

    // Encode the one-hot winner into an index.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            gnt_idx = gnt_idx | (gnt_onehot[i] ? PW'(i) : '0);
        end
    end

endmodule

// File: rtl/dram_req_arbiter.sv
// Round-robin arbiter sharing one DRAM command channel between NUM_MASTERS GPU
// requesters, one single-beat transaction in flight at a time, with a response
// watchdog that turns a hung access into an error response.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/ready/we         per-master handshake and write flag
//   req_addr/req_wdata         flattened per-master fields (master i at [i*W +: W])
//   rsp_valid/rdata/err        registered one-cycle response to the granted master
//   m_cmd_*                    command to the downstream AXI master FSM
//   m_rsp_*                    completion from the downstream FSM
//   o_busy                     arbiter not idle in ARB
//   o_gnt_id                   current / last granted master
// ADDR_WIDTH / DATA_WIDTH must not exceed the package request field widths.
module dram_req_arbiter
    import gpu_mem_pkg::*;
#(
    parameter  int NUM_MASTERS    = 3,
    parameter  int ADDR_WIDTH     = 32,
    parameter  int DATA_WIDTH     = 32,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int GW             = $clog2(NUM_MASTERS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS-1:0]            req_valid,
    output logic [NUM_MASTERS-1:0]            req_ready,
    input  logic [NUM_MASTERS-1:0]            req_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_MASTERS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic                              rsp_err,
    output logic                              m_cmd_valid,
    input  logic                              m_cmd_ready,
    output logic                              m_cmd_we,
    output logic [ADDR_WIDTH-1:0]             m_cmd_addr,
    output logic [DATA_WIDTH-1:0]             m_cmd_wdata,
    input  logic                              m_rsp_valid,
    output logic                              m_rsp_ready,
    input  logic [DATA_WIDTH-1:0]             m_rsp_rdata,
    input  logic                              m_rsp_err,
    output logic                              o_busy,
    output logic [GW-1:0]                     o_gnt_id
);

    // A zero timeout disables the watchdog; keep the counter at least one bit wide.
    localparam int          CW        = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [GW-1:0] LAST_IDX = GW'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    arb_state_t             state_q;
    logic [GW-1:0]          rr_ptr_q;
    logic [GW-1:0]          gnt_id_q;
    mem_req_t               req_q;
    logic [CW-1:0]          wd_cnt_q;
    logic [NUM_MASTERS-1:0] rsp_valid_q;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q;
    logic                   rsp_err_q;

    logic [NUM_MASTERS-1:0] pick_gnt_s;
    logic [GW-1:0]          pick_idx_s;
    logic                   pick_any_s;
    logic                   wd_fire_s;

    rr_pick #(.N(NUM_MASTERS)) u_rr_pick (
        .req        (req_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (pick_gnt_s),
        .gnt_idx    (pick_idx_s),
        .any        (pick_any_s)
    );

    assign wd_fire_s = WDOG_EN && (wd_cnt_q == TO_LAST);

    // The accept is suppressed while reset is asserted so no requester sees a
    // handshake the FSM is about to discard.
    assign req_ready   = ((state_q == ARB) && rst_n) ? pick_gnt_s : '0;
    assign m_cmd_valid = (state_q == CMD);
    assign m_cmd_we    = req_q.we;
    assign m_cmd_addr  = req_q.addr[ADDR_WIDTH-1:0];
    assign m_cmd_wdata = req_q.wdata[DATA_WIDTH-1:0];
    assign m_rsp_ready = (state_q == RSP) || (state_q == DRAIN);
    assign o_busy      = (state_q != ARB);
    assign o_gnt_id    = gnt_id_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;

    // Arbitration FSM, request latch, watchdog and registered response path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            gnt_id_q    <= '0;
            req_q       <= '0;
            wd_cnt_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                ARB: begin
                    if (pick_any_s) begin
                        req_q.we    <= req_we[pick_idx_s];
                        req_q.addr  <= MEM_ADDR_W'(req_addr[pick_idx_s*ADDR_WIDTH +: ADDR_WIDTH]);
                        req_q.wdata <= MEM_DATA_W'(req_wdata[pick_idx_s*DATA_WIDTH +: DATA_WIDTH]);
                        gnt_id_q    <= pick_idx_s;
                        rr_ptr_q    <= (pick_idx_s == LAST_IDX) ? '0 : pick_idx_s + GW'(1'b1);
                        state_q     <= CMD;
                    end
                end
                CMD: begin
                    if (m_cmd_ready) begin
                        wd_cnt_q <= '0;
                        state_q  <= RSP;
                    end
                end
                RSP: begin
                    if (wd_cnt_q != CNT_MAX) begin
                        wd_cnt_q <= wd_cnt_q + CW'(1'b1);
                    end
                    // A real completion takes precedence over a same-cycle timeout.
                    if (m_rsp_valid) begin
                        rsp_valid_q <= ONE_HOT0 << gnt_id_q;
                        rsp_rdata_q <= req_q.we ? '0 : m_rsp_rdata;
                        rsp_err_q   <= m_rsp_err;
                        state_q     <= ARB;
                    end else if (wd_fire_s) begin
                        rsp_valid_q <= ONE_HOT0 << gnt_id_q;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Swallow the late completion so it cannot be paired with a new grant.
                    if (m_rsp_valid) begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Directed bench for dram_req_arbiter (3 masters, 32-bit paths, 8-cycle watchdog).
// A table of transactions covers grant order and data routing; hand-written
// sequences cover command stall, watchdog timeout with drain, and reset mid-flight.
module tb_dram_req_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, m_rsp_rdata, m_cmd_wdata;
    logic [AW-1:0]   m_cmd_addr;
    logic            rsp_err, m_cmd_valid, m_cmd_ready, m_cmd_we;
    logic            m_rsp_valid, m_rsp_ready, m_rsp_err, o_busy;
    logic [1:0]      o_gnt_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dram_req_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_we(m_cmd_we),
        .m_cmd_addr(m_cmd_addr), .m_cmd_wdata(m_cmd_wdata),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
        .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err),
        .o_busy(o_busy), .o_gnt_id(o_gnt_id)
    );

    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  we;
        int          rsp_dly;
        logic [31:0] d_rdata;
        logic        d_err;
        int          exp_g;
        logic [31:0] x_rdata;
        logic        x_err;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [31:0] addr_of(input int i);
        return 32'h0000_0100 + 32'(i) * 32'h0000_0100;
    endfunction

    function automatic logic [31:0] wdata_of(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        chk({tag, "_cmd_valid"}, 64'(m_cmd_valid), 64'd0);
        chk({tag, "_cmd_we"}, 64'(m_cmd_we), 64'd0);
        chk({tag, "_cmd_addr"}, 64'(m_cmd_addr), 64'd0);
        chk({tag, "_cmd_wdata"}, 64'(m_cmd_wdata), 64'd0);
        chk({tag, "_m_rsp_ready"}, 64'(m_rsp_ready), 64'd0);
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_gnt_id"}, 64'(o_gnt_id), 64'd0);
    endtask

    // Present requests, expect a grant to exp_g, finish at #1 after the accept edge.
    task automatic grant(input logic [2:0] valid, input logic [2:0] we, input int exp_g);
        bit found = 1'b0;
        req_valid = valid;
        req_we    = we;
        for (int n = 0; n < 16 && !found; n++) begin
            @(negedge clk);
            if (req_ready != '0) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("grant_seen", 64'(found), 64'd1);
        chk("grant_onehot", 64'(req_ready), 64'd1 << exp_g);
        if (found) begin
            @(posedge clk);
            #1;
        end
        req_valid = '0;
    endtask

    // Drive a transaction from CMD through the response pulse and the idle cycle after it.
    task automatic finish_txn(input int g, input logic we, input int cmd_wait, input int rsp_dly,
                              input logic [31:0] d_rdata, input logic d_err,
                              input logic [31:0] x_rdata, input logic x_err);
        for (int i = 0; i <= cmd_wait; i++) begin
            m_cmd_ready = (i == cmd_wait);
            @(negedge clk);
            chk("cmd_valid", 64'(m_cmd_valid), 64'd1);
            chk("cmd_we", 64'(m_cmd_we), 64'(we));
            chk("cmd_addr", 64'(m_cmd_addr), 64'(addr_of(g)));
            chk("cmd_wdata", 64'(m_cmd_wdata), 64'(wdata_of(g)));
            chk("cmd_no_req_ready", 64'(req_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        m_cmd_ready = 1'b0;
        for (int j = 0; j <= rsp_dly; j++) begin
            if (j == rsp_dly) begin
                m_rsp_valid = 1'b1;
                m_rsp_rdata = d_rdata;
                m_rsp_err   = d_err;
                req_valid   = '0;
            end
            @(negedge clk);
            chk("rsp_m_ready", 64'(m_rsp_ready), 64'd1);
            chk("rsp_cmd_low", 64'(m_cmd_valid), 64'd0);
            chk("rsp_not_yet", 64'(rsp_valid), 64'd0);
            chk("rsp_no_req_ready", 64'(req_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        m_rsp_valid = 1'b0;
        m_rsp_rdata = 32'h0;
        m_rsp_err   = 1'b0;
        @(negedge clk);
        chk("rsp_valid", 64'(rsp_valid), 64'd1 << g);
        chk("rsp_rdata", 64'(rsp_rdata), 64'(x_rdata));
        chk("rsp_err", 64'(rsp_err), 64'(x_err));
        chk("rsp_gnt_id", 64'(o_gnt_id), 64'(g));
        chk("rsp_busy", 64'(o_busy), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rsp_pulse_len", 64'(rsp_valid), 64'd0);
        chk("rsp_rdata_hold", 64'(rsp_rdata), 64'(x_rdata));
        chk("rsp_err_hold", 64'(rsp_err), 64'(x_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        // Writes from all three masters: grant order 0,1,2,0,1,2; rdata forced to 0.
        vecs[0]  = '{3'b111, 3'b111, 0, 32'h5555_AAAA, 1'b0, 0, 32'h0, 1'b0};
        vecs[1]  = '{3'b111, 3'b111, 1, 32'h5555_AAAA, 1'b0, 1, 32'h0, 1'b0};
        vecs[2]  = '{3'b111, 3'b111, 0, 32'h1234_0000, 1'b0, 2, 32'h0, 1'b0};
        vecs[3]  = '{3'b111, 3'b111, 2, 32'h5555_AAAA, 1'b0, 0, 32'h0, 1'b0};
        vecs[4]  = '{3'b111, 3'b111, 0, 32'h5555_AAAA, 1'b0, 1, 32'h0, 1'b0};
        vecs[5]  = '{3'b111, 3'b111, 0, 32'h5555_AAAA, 1'b0, 2, 32'h0, 1'b0};
        // Single read from m0 at 0x100.
        vecs[6]  = '{3'b001, 3'b000, 0, 32'hDEAD_BEEF, 1'b0, 0, 32'hDEAD_BEEF, 1'b0};
        // m1 alone moves the pointer to 2; then m0+m1 wraps to m0, then m1.
        vecs[7]  = '{3'b010, 3'b000, 1, 32'h1234_5678, 1'b0, 1, 32'h1234_5678, 1'b0};
        vecs[8]  = '{3'b011, 3'b000, 0, 32'hCAFE_F00D, 1'b0, 0, 32'hCAFE_F00D, 1'b0};
        vecs[9]  = '{3'b011, 3'b011, 0, 32'h7777_7777, 1'b0, 1, 32'h0, 1'b0};
        // DRAM error on an m2 read.
        vecs[10] = '{3'b100, 3'b000, 3, 32'h0BAD_F00D, 1'b1, 2, 32'h0BAD_F00D, 1'b1};

        rst_n       = 1'b0;
        req_valid   = '0;
        req_we      = '0;
        req_addr    = {addr_of(2), addr_of(1), addr_of(0)};
        req_wdata   = {wdata_of(2), wdata_of(1), wdata_of(0)};
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b0;
        m_rsp_rdata = 32'h0;
        m_rsp_err   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("reset");
        @(posedge clk);
        #1;

        for (int v = 0; v < 11; v++) begin
            grant(vecs[v].valid, vecs[v].we, vecs[v].exp_g);
            finish_txn(vecs[v].exp_g, vecs[v].we[vecs[v].exp_g], 0, vecs[v].rsp_dly,
                       vecs[v].d_rdata, vecs[v].d_err, vecs[v].x_rdata, vecs[v].x_err);
        end

        // Command stall: m1 write, ready low 5 cycles while m0/m2 also request.
        grant(3'b010, 3'b010, 1);
        req_valid = 3'b101;
        finish_txn(1, 1'b1, 5, 1, 32'h0000_0099, 1'b0, 32'h0, 1'b0);

        // Watchdog: m0 read (wrap from pointer 2), no completion for 8 RSP cycles.
        grant(3'b001, 3'b000, 0);
        m_cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        m_cmd_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("wd_wait_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("wd_wait_m_rsp_ready", 64'(m_rsp_ready), 64'd1);
            @(posedge clk);
            #1;
        end
        req_valid = 3'b010;
        req_we    = 3'b000;
        @(negedge clk);
        chk("wd_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("wd_rsp_err", 64'(rsp_err), 64'd1);
        chk("wd_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("wd_drain_busy", 64'(o_busy), 64'd1);
        chk("wd_drain_no_grant", 64'(req_ready), 64'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("drain_no_grant", 64'(req_ready), 64'd0);
            chk("drain_m_rsp_ready", 64'(m_rsp_ready), 64'd1);
            chk("drain_rsp_valid", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        m_rsp_valid = 1'b1;
        m_rsp_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("drain_late_no_grant", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        m_rsp_valid = 1'b0;
        m_rsp_rdata = 32'h0;
        @(negedge clk);
        chk("late_rsp_discarded", 64'(rsp_valid), 64'd0);
        chk("late_rdata_not_leaked", 64'(rsp_rdata), 64'd0);
        chk("late_err_held", 64'(rsp_err), 64'd1);
        chk("post_drain_grant", 64'(req_ready), 64'b010);
        @(posedge clk);
        #1;
        req_valid = '0;
        finish_txn(1, 1'b0, 0, 0, 32'h600D_CAFE, 1'b0, 32'h600D_CAFE, 1'b0);

        // Reset during RSP with the pointer at 2; afterwards m0 must win over m2.
        grant(3'b010, 3'b000, 1);
        m_cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        m_cmd_ready = 1'b0;
        @(negedge clk);
        chk("pre_reset_in_rsp", 64'(m_rsp_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("midreset");
        @(posedge clk);
        #1;
        grant(3'b101, 3'b000, 0);
        finish_txn(0, 1'b0, 0, 0, 32'h1111_2222, 1'b0, 32'h1111_2222, 1'b0);
        grant(3'b100, 3'b000, 2);
        finish_txn(2, 1'b0, 0, 1, 32'h3333_4444, 1'b0, 32'h3333_4444, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
